// File: rtl/intr_ctrl_vec.sv
// Vectored interrupt controller: NumSrc level/edge sources routed to NumTgt targets with per-target enable and claim.
// Optional input synchroniser is enabled by defining INTR_CTRL_VEC_SYNC_EN.

package intr_ctrl_vec_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module intr_ctrl_vec #(
    parameter int unsigned NumSrc = 16,
    parameter int unsigned NumTgt = 2,
    parameter type reg_req_t = intr_ctrl_vec_pkg::reg_req_t,
    parameter type reg_rsp_t = intr_ctrl_vec_pkg::reg_rsp_t
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  reg_req_t          reg_req_i,
    output reg_rsp_t          reg_rsp_o,
    input  logic [NumSrc-1:0] intr_i,
    output logic [NumTgt-1:0] irq_o
);

    localparam int unsigned IdW = 6;

    logic [NumSrc-1:0]             intr_s;
    logic [NumSrc-1:0]             intr_q;
    logic [NumSrc-1:0]             pend_q, pend_d;
    logic [NumSrc-1:0]             mode_q, mode_d;
    logic [NumTgt-1:0][NumSrc-1:0] en_q, en_d;
    logic [NumTgt-1:0]             irq_d;

`ifdef INTR_CTRL_VEC_SYNC_EN
    logic [NumSrc-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= intr_i;
            sync_q2 <= sync_q1;
        end
    end

    assign intr_s = sync_q2;
`else
    assign intr_s = intr_i;
`endif

    // Address decode
    logic [7:0]  off;
    logic        acc_pend, acc_mode, acc_en, acc_claim, tgt_ok, mapped;
    logic [1:0]  tgt;
    logic        do_wr, do_rd;

    assign off = reg_req_i.addr[7:0];

    always_comb begin
        acc_pend  = 1'b0;
        acc_mode  = 1'b0;
        acc_en    = 1'b0;
        acc_claim = 1'b0;
        tgt       = 2'd0;
        case (off)
            8'h00: acc_pend = 1'b1;
            8'h04: acc_mode = 1'b1;
            8'h08, 8'h0C, 8'h10, 8'h14: begin
                acc_en = 1'b1;
                tgt    = 2'(off[4:2] - 3'd2);
            end
            8'h20, 8'h24, 8'h28, 8'h2C: begin
                acc_claim = 1'b1;
                tgt       = off[3:2];
            end
            default: ;
        endcase
        tgt_ok = 32'(tgt) < NumTgt;
        mapped = (reg_req_i.addr[31:8] == 24'd0) &&
                 (acc_pend || acc_mode || ((acc_en || acc_claim) && tgt_ok));
    end

    assign do_wr = reg_req_i.valid &&  reg_req_i.write && mapped;
    assign do_rd = reg_req_i.valid && !reg_req_i.write && mapped;

    // Byte-strobed write data, truncated to the implemented source bits
    logic [31:0]       wmask32, wval32;
    logic [NumSrc-1:0] wmsk, wbits;

    assign wmask32 = {{8{reg_req_i.wstrb[3]}}, {8{reg_req_i.wstrb[2]}},
                      {8{reg_req_i.wstrb[1]}}, {8{reg_req_i.wstrb[0]}}};
    assign wval32  = reg_req_i.wdata & wmask32;
    assign wmsk    = NumSrc'(wmask32);
    assign wbits   = NumSrc'(wval32);

    // Claim: lowest pending-and-enabled source of the addressed target
    logic [NumSrc-1:0] masked, claim_oh, claim_clr;
    logic [IdW-1:0]    claim_id;

    always_comb begin
        masked = '0;
        for (int t = 0; t < int'(NumTgt); t++) begin
            if (tgt == 2'(t)) masked = pend_q & en_q[t];
        end
        claim_oh = masked & (~masked + NumSrc'(1));
        claim_id = '0;
        for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
            if (masked[i]) claim_id = IdW'(i + 1);
        end
        claim_clr = (do_rd && acc_claim) ? (claim_oh & mode_q) : '0;
    end

    // Read mux and response
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (do_rd) begin
            if (acc_pend)  rdata = 32'(pend_q);
            if (acc_mode)  rdata = 32'(mode_q);
            if (acc_claim) rdata = 32'(claim_id);
            if (acc_en) begin
                for (int t = 0; t < int'(NumTgt); t++) begin
                    if (tgt == 2'(t)) rdata = 32'(en_q[t]);
                end
            end
        end
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rdata;
        reg_rsp_o.error = reg_req_i.valid && !mapped;
        reg_rsp_o.ready = reg_req_i.valid;
    end

    // Next-state: a newly edge-mode bit restarts from its edge detector only
    logic [NumSrc-1:0] edge_set, w1c, to_edge;

    always_comb begin
        mode_d = mode_q;
        en_d   = en_q;
        if (do_wr && acc_mode) mode_d = (mode_q & ~wmsk) | wbits;
        for (int t = 0; t < int'(NumTgt); t++) begin
            if (do_wr && acc_en && tgt == 2'(t)) en_d[t] = (en_q[t] & ~wmsk) | wbits;
            irq_d[t] = |(pend_q & en_q[t]);
        end
        edge_set = intr_s & ~intr_q;
        w1c      = (do_wr && acc_pend) ? wbits : '0;
        to_edge  = mode_d & ~mode_q;
        pend_d   = (mode_q & (edge_set | (pend_q & ~(w1c | claim_clr)))) |
                   (~mode_q & ~to_edge & intr_s) |
                   (to_edge & edge_set);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            intr_q <= '0;
            pend_q <= '0;
            mode_q <= '0;
            en_q   <= '0;
            irq_o  <= '0;
        end else begin
            intr_q <= intr_s;
            pend_q <= pend_d;
            mode_q <= mode_d;
            en_q   <= en_d;
            irq_o  <= irq_d;
        end
    end

endmodule

// File: doc/intr_ctrl_vec.md
Name: intr_ctrl_vec

Overview:
- Parametrised successor to the fixed 16-line fast interrupt controller.
- Takes NumSrc interrupt sources, each selectable as level or rising-edge, and routes them to NumTgt CPU interrupt targets, each with its own enable mask and claim register.
- Sits on the peripheral register bus as one reg slave; its irq_o drives the CPU subsystem irq inputs.

Parameters:
- NumSrc, 16, number of interrupt sources (1..32).
- NumTgt, 2, number of interrupt targets (1..4).
- reg_req_t, logic, register-bus request struct type.
- reg_rsp_t, logic, register-bus response struct type.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- reg_req_i  input  reg_req_t  register-bus request (addr, write, wdata, wstrb, valid).
- reg_rsp_o  output  reg_rsp_t  register-bus response (rdata, error, ready).
- intr_i  input  NumSrc  interrupt source lines.
- irq_o  output  NumTgt  per-target interrupt request, registered.

Behaviour:
- Reset (rst_i high, async): PENDING=0, MODE=0 (all level), ENABLE_t=0, irq_o=0, source sample register intr_q=0.
- Register map (word offsets):
  - 0x00 PENDING: RW1C for edge sources; read-only mirror for level sources.
  - 0x04 MODE: bit=1 selects edge.
  - 0x08+4*t ENABLE_t.
  - 0x20+4*t CLAIM_t, read-only.
- Register-bus responses:
  - ready=1 in the same cycle as valid; rdata is combinational.
  - Writes honour wstrb per byte.
  - Unmapped offset, or t>=NumTgt: error=1, rdata=0, no side effect.
  - Bits [31:NumSrc] read 0; writes to them are ignored.
- Sampling: intr_q <= intr_s every cycle, where intr_s = intr_i (see Optional Feature).
- Level source: PENDING[i] <= intr_s[i] every cycle.
- Edge source:
  - PENDING[i] set when intr_s[i] & ~intr_q[i].
  - Cleared by W1C write or by a claim.
  - Set wins over clear in the same cycle.
- Output: irq_o[t] <= |(PENDING & ENABLE_t), registered.
  - Latency from intr_i rising to irq_o high: 2 cycles without sync.
- CLAIM_t read:
  - Returns id+1 of the lowest-index bit set in PENDING & ENABLE_t; returns 0 if none.
  - In the same cycle, clears that PENDING bit if the source is edge mode; level sources are not cleared.
  - Writes to CLAIM_t: error=0, ignored.
- MODE change:
  - level->edge: PENDING[i] cleared that cycle. Because intr_q is already 1 for a held-high line, no spurious edge.
  - edge->level: PENDING[i] follows the input from the next cycle.
- Boundary cases:
  - Source already high at reset release, in edge mode: no edge until the line drops and rises again.
  - Claim and new edge on the same source in the same cycle: the bit stays pending.
  - Reset mid-operation: all state returns to reset values immediately.

Optional Feature:
- Macro INTR_CTRL_VEC_SYNC_EN.
- Defined: intr_s comes from a 2-flop synchroniser per source, reset to 0. Latency from intr_i to irq_o becomes 4 cycles.
- Undefined: intr_s = intr_i; sources are assumed synchronous to clk_i.
- Register map and claim semantics are identical in both builds.

Test Plan:
- Reset check: after reset, read 0x00, 0x04, 0x08 -> all 0; irq_o=0; unmapped read of 0x40 -> error=1, rdata=0.
- Level path: write ENABLE_0=0x0000_0008; hold intr_i[3]=1 -> irq_o[0]=1 two cycles later (four with SYNC_EN); CLAIM_0 reads 4 and PENDING[3] stays 1; drop intr_i[3] -> irq_o[0]=0 two cycles later.
- Edge path: MODE=0x0000_0021, ENABLE_1=0x21; pulse intr_i[0] and intr_i[5] for 1 cycle each -> PENDING=0x21, irq_o[1]=1; CLAIM_1 reads 1 then 6 then 0; irq_o[1]=0 after the second claim.
- W1C collision: edge source 2 pending; write 0x04 to PENDING in the same cycle as a new rising edge on intr_i[2] -> PENDING[2] stays 1.
- Mode switch: intr_i[7] held at 1 in level mode, then MODE[7] set to 1 -> PENDING[7]=0 and stays 0 while the line is held; drop then raise the line -> PENDING[7]=1.
- Byte strobes and width: NumSrc=10; write ENABLE_0=0xFFFF_FFFF with wstrb=0b0001 -> reads 0x0000_00FF; write again with wstrb=0b1111 -> reads 0x0000_03FF.
